sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM between the per-pixel sprite fetchers: Pac-Man and the red, green and blue ghosts.
- Grants at most one ROM read per Clk using round-robin arbitration.
- Drives the ROM address and read strobe.
- Routes each returned RGB word, tagged, back to the requester that issued it. That requester's data then feeds the colour mapper's per-sprite RGB inputs.

Parameters:
- N_REQ, 4, number of requesters; index 0 is Pac-Man, 1 red, 2 green, 3 blue.
- ADDR_W, 10, sprite ROM address width.
- DATA_W, 24, ROM word width (R, G, B, 8 bits each).
- ROM_LAT, 2, Clk cycles from rom_rd to valid rom_data; range 1..4.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- arb_en  in  1  enables new grants; low stops new grants, in-flight reads still complete
- req  in  N_REQ  per-requester read request, level
- req_addr  in  N_REQ*ADDR_W  per-requester address; slice i is bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant pulse
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  N_REQ  one-hot response-valid pulse
- rsp_data  out  DATA_W  response data, shared by all requesters
- busy  out  1  at least one read in flight

Behaviour:
- Reset (Reset_n low, asynchronous) clears:
  - gnt, rom_rd, rom_addr, rsp_valid, rsp_data and busy to 0;
  - round-robin pointer rr_ptr to 0;
  - tag pipeline to empty;
  - state to IDLE.
- States:
  - IDLE: no grants. Go to ARB on frame_start, or when arb_en=1 and any req is high.
  - ARB: one arbitration decision per cycle. Go to DRAIN when arb_en falls.
  - DRAIN: no new grants. Go to IDLE when the tag pipeline is empty.
  - frame_start in any state sets rr_ptr to 0 and does not discard in-flight reads.
- Arbitration, in ARB with arb_en=1, for cycle t:
  - Eligible set = req & ~mask. mask is the one-hot of the requester granted at t-1, which suppresses a double grant while that requester drops req.
  - Winner = first eligible index searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
  - Registered outputs at t+1:
    - gnt[winner]=1 and rom_rd=1;
    - rom_addr = req_addr slice sampled at t.
  - rr_ptr then becomes (winner+1) mod N_REQ.
  - If no requester is eligible: gnt=0, rom_rd=0, rom_addr holds, rr_ptr unchanged.
- Requester contract:
  - Hold req and the address stable until gnt is seen.
  - Deassert req in the cycle after gnt, unless it wants another read.
- Response:
  - The tag pipeline is ROM_LAT deep; each stage holds a valid bit and the requester index.
  - rsp_valid[idx] pulses, and rsp_data captures rom_data, exactly ROM_LAT cycles after the matching rom_rd.
  - Total latency from req sampled to rsp_valid is ROM_LAT+1 cycles.
- Throughput and overlap:
  - Full pipelining, one read per cycle, so there is no full condition.
  - A response and a new grant in the same cycle are independent.
- busy = OR of the tag-pipeline valid bits.
- Mid-operation:
  - Asynchronous reset drops in-flight tags; no response is issued.
  - When arb_en falls, the grant already registered completes normally.

Optional Feature:
- Macro SPRITE_ARB_PAC_PRIO_EN.
- Defined: requester 0 (Pac-Man) wins whenever it is eligible. The other requesters rotate round-robin among indices 1..N_REQ-1, and rr_ptr never points at 0.
- Undefined: pure round-robin over all N_REQ requesters, as above.

Decomposition:
- Package sprite_arb_pkg holds:
  - arb_state_t enum {IDLE, ARB, DRAIN};
  - constant IDX_W = $clog2(N_REQ);
  - tag_t struct {valid, idx}.
- Sub-module rr_pick: combinational round-robin first-one finder, inputs eligible vector and rr_ptr, outputs winner index and found flag.
- Tag pipeline and FSM stay in the top module.

Test Plan:
- Single request:
  - Stimulus: req=0001, addr0=0x155, ROM returns 0xFFFF00.
  - Required: gnt=0001 and rom_addr=0x155 one cycle later; rsp_valid=0001 and rsp_data=0xFFFF00 three cycles after req (ROM_LAT=2).
- Full contention:
  - Stimulus: req=1111 held continuously.
  - Required: grant order 0,1,2,3,0,1… with one gnt per cycle and rsp_valid following the same order offset by 2.
- Back-to-back from one requester:
  - Stimulus: req1 held 4 cycles.
  - Required: gnt1 on alternate cycles only, because of the mask; no duplicate grant.
- arb_en drop:
  - Stimulus: arb_en 1→0 while 2 reads are in flight.
  - Required: no new gnt; both rsp_valid pulses arrive; busy falls to 0; state returns to IDLE.
- frame_start:
  - Stimulus: frame_start pulse with rr_ptr=2 and req=1111.
  - Required: next grant goes to 0.
- Reset and priority:
  - Reset_n low mid-flight: all outputs 0 immediately, no rsp_valid afterward.
  - With SPRITE_ARB_PAC_PRIO_EN and req=1111 held: requester 0 wins on every cycle it is eligible, i.e. whenever it was not granted the previous cycle (order 0,1,0,2,0,3).

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter: FSM state encoding,
// requester index width and the tag carried alongside each in-flight ROM read.
package sprite_arb_pkg;

  localparam int unsigned SPRITE_N_REQ = 4;
  localparam int unsigned IDX_W        = $clog2(SPRITE_N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set bit of
// eligible at or above rr_ptr, wrapping to index 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan downward so the last hit in each half is the lowest index there.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (eligible[j]) begin
        if (j >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(j);
        end
      end
    end
    found  = hi_found | lo_found;
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between Pac-Man and three ghosts,
// with a tag pipeline routing each ROM word back to its requester.
// Define SPRITE_ARB_PAC_PRIO_EN to give requester 0 (Pac-Man) fixed priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = SPRITE_N_REQ,  // must match the package's SPRITE_N_REQ
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic                    arb_en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_rd,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int LAST = ROM_LAT - 1;

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] ptr_after;
  logic [IDX_W-1:0] rr_winner;
  logic [IDX_W-1:0] winner;
  logic             rr_found;
  logic             found;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_vec;
  logic [N_REQ-1:0] gnt_nxt;
  logic             rom_rd_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  tag_t             tag_q [ROM_LAT];

  // Last cycle's grant is the mask: a requester still holding req while it
  // sees its grant cannot win twice in a row.
  assign eligible = req & ~gnt;

`ifdef SPRITE_ARB_PAC_PRIO_EN
  localparam logic [IDX_W-1:0] PTR_HOME = IDX_W'(1);

  assign pick_vec  = {eligible[N_REQ-1:1], 1'b0};
  assign winner    = eligible[0] ? '0 : rr_winner;
  assign found     = eligible[0] | rr_found;
  // Pac-Man wins leave the ghost rotation untouched; it wraps N_REQ-1 -> 1.
  assign ptr_after = eligible[0] ? ptr_eff :
                     (rr_winner == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : rr_winner + IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] PTR_HOME = '0;

  assign pick_vec  = eligible;
  assign winner    = rr_winner;
  assign found     = rr_found;
  assign ptr_after = (rr_winner == IDX_W'(N_REQ - 1)) ? '0 : rr_winner + IDX_W'(1);
`endif

  // frame_start homes the pointer for the decision made in the same cycle.
  assign ptr_eff = frame_start ? PTR_HOME : rr_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible (pick_vec),
    .rr_ptr   (ptr_eff),
    .winner   (rr_winner),
    .found    (rr_found)
  );

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = '0;
    rom_rd_nxt   = 1'b0;
    rom_addr_nxt = rom_addr;
    rr_ptr_nxt   = ptr_eff;
    unique case (state)
      IDLE: begin
        if (frame_start || (arb_en && |req)) state_nxt = ARB;
      end
      ARB: begin
        if (!arb_en) begin
          state_nxt = DRAIN;
        end else if (found) begin
          gnt_nxt      = N_REQ'(1) << winner;
          rom_rd_nxt   = 1'b1;
          rom_addr_nxt = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          rr_ptr_nxt   = ptr_after;
        end
      end
      DRAIN: begin
        if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      rr_ptr   <= PTR_HOME;
      gnt      <= '0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gnt      <= gnt_nxt;
      rom_rd   <= rom_rd_nxt;
      rom_addr <= rom_addr_nxt;
    end
  end

  // Stage 0 loads alongside rom_rd; the last stage fires rsp_valid as the
  // ROM word for that read is captured.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the tag pipeline is reset, not left uninitialised like a data
      // memory, because its valid bits directly drive busy and rsp_valid.
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag_q[0] <= '{valid: rom_rd_nxt, idx: winner};
      for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid <= tag_q[LAST].valid ? (N_REQ'(1) << tag_q[LAST].idx) : '0;
      if (tag_q[LAST].valid) rsp_data <= rom_data;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) busy = busy | tag_q[i].valid;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed stimulus pushes expected
// grants and responses (with their cycle) into queues; a monitor pops them.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int RSP_DLY = 2;  // ROM_LAT of the default build

  typedef struct {
    int          cyc;
    logic [3:0]  vec;
    logic [23:0] val;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        arb_en;
  logic [3:0]  req;
  logic [39:0] req_addr;
  logic [3:0]  gnt;
  logic        rom_rd;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic [3:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic        busy;

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  exp_t gnt_q[$];
  exp_t rsp_q[$];
  exp_t ge;
  exp_t re;

  logic [9:0] base [4] = '{10'h155, 10'h2AA, 10'h0F0, 10'h3C3};
  int         order7 [6];
  int         order2 [8];

  sprite_rom_arbiter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .arb_en      (arb_en),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_rd      (rom_rd),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom_word(input logic [9:0] a);
    if (a == 10'h155) return 24'hFFFF00;
    return {4'hC, 2'b00, a, 8'h3C};
  endfunction

  // Synchronous ROM: one register stage, so data is captured RSP_DLY after rom_rd.
  always @(posedge Clk) rom_data <= rom_rd ? rom_word(rom_addr) : '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_gnt(input int c, input int idx);
    gnt_q.push_back('{cyc: c, vec: 4'(1 << idx), val: 24'(base[idx])});
  endtask

  task automatic expect_read(input int c, input int idx);
    push_gnt(c, idx);
    rsp_q.push_back('{cyc: c + RSP_DLY, vec: 4'(1 << idx), val: rom_word(base[idx])});
  endtask

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      while (gnt_q.size() != 0 && gnt_q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL gnt_missing: expected gnt 0x%0h at cycle %0d, none by cycle %0d",
                 gnt_q[0].vec, gnt_q[0].cyc, cyc);
        void'(gnt_q.pop_front());
      end
      while (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_missing: expected rsp_valid 0x%0h at cycle %0d, none by cycle %0d",
                 rsp_q[0].vec, rsp_q[0].cyc, cyc);
        void'(rsp_q.pop_front());
      end
      if (gnt != 0 || rom_rd) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'({gnt, rom_rd}), 64'(0));
        end else begin
          ge = gnt_q.pop_front();
          check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
          check("gnt", 64'(gnt), 64'(ge.vec));
          check("rom_rd", 64'(rom_rd), 64'(1));
          check("rom_addr", 64'(rom_addr), 64'(ge.val[9:0]));
        end
      end
      if (rsp_valid != 0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          re = rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(re.cyc));
          check("rsp_valid", 64'(rsp_valid), 64'(re.vec));
          check("rsp_data", 64'(rsp_data), 64'(re.val));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 ns");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_rom_rd"}, 64'(rom_rd), 64'(0));
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_state"}, 64'(dut.state), 64'(IDLE));
  endtask

  initial begin
    int t;
`ifdef SPRITE_ARB_PAC_PRIO_EN
    order2 = '{0, 1, 0, 2, 0, 3, 0, 1};
    order7 = '{0, 1, 0, 2, 0, 3};
`else
    order2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    order7 = '{0, 1, 2, 3, 0, 1};
`endif
    frame_start = 1'b0;
    arb_en      = 1'b0;
    req         = '0;
    req_addr    = {base[3], base[2], base[1], base[0]};
    Reset_n     = 1'b1;
    #2 Reset_n  = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) step();
    Reset_n = 1'b1;
    step();

    // Enter ARB with no requests pending.
    arb_en = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("state_arb", 64'(dut.state), 64'(ARB));

    // Single request from Pac-Man.
    req = 4'b0001;
    expect_read(cyc + 1, 0);
    step();
    req = '0;
    repeat (4) step();

    // Full contention with the pointer homed.
    frame_start = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      expect_read(cyc + 1, order2[i]);
      step();
      frame_start = 1'b0;
    end
    req = '0;
    repeat (4) step();

    // One requester holding req: the mask allows only alternate grants.
    t = cyc;
    req = 4'b0010;
    expect_read(t + 1, 1);
    expect_read(t + 3, 1);
    repeat (4) step();
    req = '0;
    repeat (4) step();

    // arb_en drop with two reads in flight.
    t = cyc;
    req = 4'b0110;
    expect_read(t + 1, 2);
    step();
    req = 4'b0010;
    expect_read(t + 2, 1);
    step();
    arb_en = 1'b0;
    req = 4'b1000;
    step();
    check("drain_busy", 64'(busy), 64'(1));
    check("drain_state", 64'(dut.state), 64'(DRAIN));
    step();
    check("drain_busy_low", 64'(busy), 64'(0));
    step();
    check("drain_idle", 64'(dut.state), 64'(IDLE));
    req = '0;
    repeat (2) step();

    // frame_start while rr_ptr = 2 and all requesting: next grant is 0.
    t = cyc;
    arb_en = 1'b1;
    req = 4'b1111;
    step();
    check("fs_ptr_before", 64'(dut.rr_ptr), 64'(2));
    frame_start = 1'b1;
    expect_read(t + 2, 0);
    step();
    frame_start = 1'b0;
    expect_read(t + 3, 1);
    step();
    req = '0;
    repeat (4) step();

    // Reset with a read in flight: outputs clear at once, no response follows.
    t = cyc;
    req = 4'b0001;
    push_gnt(t + 1, 0);
    step();
    req = '0;
    step();
    check("mid_busy", 64'(busy), 64'(1));
    Reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) step();
    Reset_n = 1'b1;
    repeat (5) step();

    // Contention straight out of reset (pointer from reset value).
    req = 4'b1111;
    step();
    for (int i = 0; i < 6; i++) begin
      expect_read(cyc + 1, order7[i]);
      step();
    end
    req = '0;
    repeat (6) step();

    check("gnt_queue_empty", 64'(gnt_q.size()), 64'(0));
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
